// File: rtl/alu_muldiv.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU over WIDTH steps,
// plus single-cycle MTHI/MTLO writes and result-overwrite tracking.
//
// Handshake: an operation is accepted on a rising edge where start_i=1 and
// ready_o=1. ready_o is high only in IDLE. start_i seen while busy is dropped,
// not queued. done_o and the error flags are one-cycle pulses that are visible
// in the cycle after the edge that produced them.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             rd_hilo_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             err_div0_o,
  output logic             err_ovw_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_hi, r_lo;
  // r_acc: partial product high half / partial remainder.
  // r_q:   multiplier shifting out / dividend shifting out, quotient shifting in.
  // r_opb: multiplicand / divisor magnitude.
  logic [WIDTH-1:0] r_acc, r_q, r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;   // product (MUL) or quotient (DIV) must be negated
  logic             r_neg_r;   // remainder must be negated (dividend was negative)
  logic             r_pend;
  logic             r_done, r_div0, r_ovw;

  logic             w_accept, w_is_md, w_is_div, w_signed, w_div0, w_launch;
  logic             w_mthi, w_mtlo;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  // Request decode and operand magnitude/sign extraction.
  always_comb begin
    w_accept = start_i & (r_state == S_IDLE);
    w_is_md  = (op_i == OP_MULT) | (op_i == OP_MULTU) |
               (op_i == OP_DIV)  | (op_i == OP_DIVU);
    w_is_div = (op_i == OP_DIV) | (op_i == OP_DIVU);
    w_signed = (op_i == OP_MULT) | (op_i == OP_DIV);
    w_div0   = w_accept & w_is_div & (src2_i == '0);
    w_launch = w_accept & w_is_md & ~(w_is_div & (src2_i == '0));
    w_mthi   = w_accept & (op_i == OP_MTHI);
    w_mtlo   = w_accept & (op_i == OP_MTLO);
    w_a_neg  = w_signed & src1_i[WIDTH-1];
    w_b_neg  = w_signed & src2_i[WIDTH-1];
    w_a_mag  = w_a_neg ? (~src1_i + WIDTH'(1)) : src1_i;
    w_b_mag  = w_b_neg ? (~src2_i + WIDTH'(1)) : src2_i;
  end

  // One iteration step of shift-add multiply and restoring divide.
  always_comb begin
    w_mul_sum = r_q[0] ? ({1'b0, r_acc} + {1'b0, r_opb}) : {1'b0, r_acc};
    w_shift   = {r_acc, r_q[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_opb});
    // When w_ge holds the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    w_sub     = w_shift[WIDTH-1:0] - r_opb;
  end

  // Sign correction applied in FIX.
  always_comb begin
    w_prod     = {r_acc, r_q};
    w_prod_fix = r_neg_q ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    w_quo_fix  = r_neg_q ? (~r_q + WIDTH'(1)) : r_q;
    w_rem_fix  = r_neg_r ? (~r_acc + WIDTH'(1)) : r_acc;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_RUN;
      S_RUN:   if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_launch) begin
      r_acc    <= '0;
      r_q      <= w_a_mag;
      r_opb    <= w_b_mag;
      r_cnt    <= '0;
      r_is_div <= w_is_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_is_div) begin
        r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end else begin
        r_acc <= w_mul_sum[WIDTH:1];
        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
      end
    end
  end

  // HI/LO registers: written only by the FIX step or by MTHI/MTLO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      if (r_is_div) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
        r_lo <= w_prod_fix[WIDTH-1:0];
      end
    end else begin
      if (w_mthi) r_hi <= src1_i;
      if (w_mtlo) r_lo <= src1_i;
    end
  end

  // Unread-result tracking and status pulses; a fresh write beats a same-edge read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= 1'b0;
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      r_ovw  <= 1'b0;
    end else begin
      if ((r_state == S_FIX) | w_mthi | w_mtlo) r_pend <= 1'b1;
      else if (rd_hilo_i)                       r_pend <= 1'b0;
      r_done <= (r_state == S_FIX) | w_div0;
      r_div0 <= w_div0;
      r_ovw  <= w_accept & w_is_md & r_pend & ~rd_hilo_i;
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign busy_o      = ~ready_o;
  assign done_o      = r_done;
  assign err_div0_o  = r_div0;
  assign err_ovw_o   = r_ovw;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign dbg_state_o = r_state;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal values 8..64, even.
REQ-002 Parameter CNT_W, default 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 start_i  input  1  operation request; accepted only when ready_o=1.
REQ-006 op_i  input  3  operation code: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
REQ-007 src1_i  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-008 src2_i  input  WIDTH  multiplier / divisor.
REQ-009 rd_hilo_i  input  1  pulse: consumer has read HI or LO (MFHI/MFLO executed).
REQ-010 ready_o  output  1  high when in IDLE and able to accept start_i.
REQ-011 busy_o  output  1  inverse of ready_o.
REQ-012 done_o  output  1  one-cycle pulse: HI/LO updated by a MULT/MULTU/DIV/DIVU.
REQ-013 hi_o  output  WIDTH  HI register, always driven.
REQ-014 lo_o  output  WIDTH  LO register, always driven.
REQ-015 err_div0_o  output  1  one-cycle pulse: DIV/DIVU with src2_i=0.
REQ-016 err_ovw_o  output  1  one-cycle pulse: HI/LO result overwritten before being read.

Function
REQ-017 FSM states IDLE, RUN, FIX; busy_o=1 in RUN and FIX.
REQ-018 Accept = start_i & ready_o at a rising edge (edge E0); start_i while busy is ignored, no queuing.
REQ-019 MULT/MULTU/DIV/DIVU with nonzero divisor: IDLE->RUN at E0; operands latched at E0; later operand changes have no effect.
REQ-020 RUN lasts exactly WIDTH edges (E1..E_WIDTH), one shift-add (MUL) or restoring shift-subtract (DIV) step per edge; then RUN->FIX.
REQ-021 FIX: applies sign correction, writes HI/LO and returns to IDLE at edge E_(WIDTH+1); done_o=1 and new HI/LO visible for the cycle after that edge; ready_o=1 in that same cycle.
REQ-022 MULT: signed 2*WIDTH-bit product; HI = upper WIDTH bits, LO = lower WIDTH bits. MULTU: unsigned, same split.
REQ-023 DIV: signed, quotient truncated toward zero into LO, remainder with sign of dividend into HI; most-negative / -1 gives LO = most-negative value, HI = 0, no error.
REQ-024 DIVU: unsigned quotient into LO, remainder into HI.
REQ-025 DIV/DIVU with src2_i=0: no RUN; stays IDLE; HI/LO unchanged; err_div0_o=1 and done_o=1 for the cycle after E0.
REQ-026 MTHI/MTLO: write src1_i to HI/LO at E0; single cycle; no done_o; stays IDLE.
REQ-027 NOP and reserved code: no state change, no pulse.
REQ-028 Pending flag set when HI/LO written by a mult/div result or MTHI/MTLO; cleared by rd_hilo_i=1 at any edge.
REQ-029 Accepting MULT/MULTU/DIV/DIVU while pending=1 and rd_hilo_i=0 pulses err_ovw_o for the cycle after E0; operation still executes.
REQ-030 rd_hilo_i and accept on the same edge: read wins, no err_ovw_o.
REQ-031 HI/LO hold their value throughout RUN/FIX until the FIX write; rd_hilo_i during busy reads old values.

Reset
REQ-032 rst_i=1 at an edge: state IDLE, HI=0, LO=0, counter=0, pending=0; ready_o=1, busy_o=0, done_o=0, err_div0_o=0, err_ovw_o=0 next cycle.
REQ-033 Reset overrides start_i and aborts any RUN/FIX in progress; no done_o for the aborted operation.

Verification (WIDTH=32)
REQ-034 MULT src1=0xFFFFFFFE, src2=0x00000003 -> done_o in the cycle after E33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 DIVU 0x1234 / 0 -> err_div0_o and done_o the cycle after E0; HI/LO unchanged; ready_o stays 1.
REQ-038 MTLO 0x55, then MULT without rd_hilo_i -> err_ovw_o pulse; start_i repeated during RUN ignored; rst_i at E10 -> IDLE, HI=LO=0, no done_o.
